// File: rtl/dncnn_host_ctrl.sv
// Host sequencer for the DnCNN core: loads the image into activation SRAM,
// starts the core, times the run and streams the Conv7 result back out.
module dncnn_host_ctrl #(
   parameter int IMG_WORDS   = 256,
   parameter int OUT_BASE    = 24832,
   parameter int OUT_WORDS   = 256,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        compute_start,
   input  logic        compute_finish,
   output logic        sram_sel,
   output logic [3:0]  sram_act_wea,
   output logic [15:0] sram_act_addr,
   output logic [31:0] sram_act_wdata,
   input  logic [31:0] sram_act_rdata,
   output logic [31:0] cycle_count,
   output logic        done,
   output logic        err
);

   localparam int LW = $clog2(IMG_WORDS);
   localparam int RW = $clog2(OUT_WORDS);
   localparam int TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      LOAD, START, WAIT, RD_REQ, RD_CAP, RD_OUT
   } state_t;

   state_t        state, state_nx;
   logic [LW-1:0] load_cnt;
   logic [RW-1:0] rd_cnt;
   logic [TW-1:0] tmo_cnt;
   logic [15:0]   addr_q;
   logic          fin_q;
   logic          in_hs, out_hs, fin_rise;
   logic          load_last, rd_last, tmo_hit;

   assign in_hs     = (state == LOAD) && in_valid;
   assign out_hs    = (state == RD_OUT) && out_ready;
   assign fin_rise  = compute_finish && !fin_q;
   assign load_last = (load_cnt == LW'(IMG_WORDS - 1));
   assign rd_last   = (rd_cnt == RW'(OUT_WORDS - 1));
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         LOAD:    if (in_hs && load_last) state_nx = START;
         START:   state_nx = WAIT;
         WAIT: begin
            if (fin_rise)     state_nx = RD_REQ;
            else if (tmo_hit) state_nx = LOAD;
         end
         RD_REQ:  state_nx = RD_CAP;
         RD_CAP:  state_nx = RD_OUT;
         RD_OUT:  if (out_ready) state_nx = rd_last ? LOAD : RD_REQ;
         default: state_nx = LOAD;
      endcase
   end

   always_comb begin
      in_ready       = 1'b0;
      sram_sel       = 1'b1;
      compute_start  = 1'b0;
      out_valid      = 1'b0;
      out_last       = 1'b0;
      sram_act_wea   = 4'b0000;
      sram_act_addr  = addr_q;
      sram_act_wdata = 32'd0;
      unique case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_hs) begin
               sram_act_wea   = 4'b1111;
               sram_act_addr  = 16'(load_cnt);
               sram_act_wdata = in_data;
            end
         end
         START: begin
            compute_start = 1'b1;
            sram_sel      = 1'b0;
         end
         WAIT:   sram_sel = 1'b0;
         RD_REQ: sram_act_addr = 16'(OUT_BASE) + 16'(rd_cnt);
         RD_CAP: sram_act_addr = 16'(OUT_BASE) + 16'(rd_cnt);
         RD_OUT: begin
            out_valid = 1'b1;
            out_last  = rd_last;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt    <= '0;
         rd_cnt      <= '0;
         tmo_cnt     <= '0;
         addr_q      <= '0;
         fin_q       <= 1'b0;
         out_data    <= '0;
         cycle_count <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         fin_q  <= compute_finish;
         addr_q <= sram_act_addr;
         done   <= out_hs && rd_last;
         if (in_hs) begin
            load_cnt <= load_last ? '0 : load_cnt + 1'b1;
            if (load_cnt == '0) err <= 1'b0;
         end
         if (state == START) begin
            cycle_count <= '0;
            tmo_cnt     <= '0;
         end
         if (state == WAIT) begin
            if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
            tmo_cnt <= tmo_cnt + 1'b1;
            if (fin_rise)     rd_cnt <= '0;
            else if (tmo_hit) err    <= 1'b1;
         end
         if (state == RD_CAP) out_data <= sram_act_rdata;
         if (out_hs && !rd_last) rd_cnt <= rd_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_dncnn_host_ctrl.sv
// Directed run sequence with random image/result data and random sink
// stalls, checked against an SRAM/core model kept in the bench.
module tb_dncnn_host_ctrl;

   localparam int TMO      = 1200;
   localparam int OUT_BASE = 24832;
   localparam int N        = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_data;
   logic        out_valid, out_ready, out_last;
   logic [31:0] out_data;
   logic        compute_start, compute_finish;
   logic        sram_sel;
   logic [3:0]  sram_act_wea;
   logic [15:0] sram_act_addr;
   logic [31:0] sram_act_wdata, sram_act_rdata;
   logic [31:0] cycle_count;
   logic        done, err;

   int vectors = 0;
   int errors  = 0;
   int n_start = 0;
   int n_done  = 0;
   int n_ov    = 0;

   logic [31:0] mem [0:65535];
   logic [31:0] img [N];
   logic [31:0] res [N];

   always #5 clk = ~clk;

   dncnn_host_ctrl #(
      .IMG_WORDS(N), .OUT_BASE(OUT_BASE), .OUT_WORDS(N), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .compute_start(compute_start), .compute_finish(compute_finish),
      .sram_sel(sram_sel), .sram_act_wea(sram_act_wea),
      .sram_act_addr(sram_act_addr), .sram_act_wdata(sram_act_wdata),
      .sram_act_rdata(sram_act_rdata),
      .cycle_count(cycle_count), .done(done), .err(err)
   );

   // Activation SRAM: host writes land in mem, the result region comes
   // from what the core model produced in res.
   always @(posedge clk) begin
      if (sram_sel && sram_act_wea == 4'hF)
         mem[sram_act_addr] <= sram_act_wdata;
      if (sram_sel) begin
         if (int'(sram_act_addr) >= OUT_BASE &&
             int'(sram_act_addr) < OUT_BASE + N)
            sram_act_rdata <= res[int'(sram_act_addr) - OUT_BASE];
         else
            sram_act_rdata <= mem[sram_act_addr];
      end
   end

   always @(negedge clk) begin
      if (compute_start) n_start++;
      if (done)          n_done++;
      if (out_valid)     n_ov++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_reset();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_sram_sel", 32'(sram_sel), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_start", 32'(compute_start), 0);
      chk("rst_wea", 32'(sram_act_wea), 0);
      chk("rst_addr", 32'(sram_act_addr), 0);
      chk("rst_wdata", sram_act_wdata, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
   endtask

   task automatic load_image(input bit err_before);
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = img[i];
         @(negedge clk);
         if (i == 0) chk("err_before_load", 32'(err), 32'(err_before));
         if (i == 1) chk("err_cleared", 32'(err), 0);
         if (i == 5 || i == N - 1) begin
            chk("ld_ready", 32'(in_ready), 1);
            chk("ld_wea", 32'(sram_act_wea), 32'hF);
            chk("ld_addr", 32'(sram_act_addr), i);
            chk("ld_wdata", sram_act_wdata, img[i]);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      for (int i = 0; i < N; i += 37)
         chk("sram_img", mem[i], img[i]);
      chk("sram_img_last", mem[N-1], img[N-1]);
   endtask

   task automatic see_start();
      int t = 0;
      while (!compute_start && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      chk("start_seen", 32'(compute_start), 1);
      chk("start_sel", 32'(sram_sel), 0);
      chk("start_in_ready", 32'(in_ready), 0);
      chk("addr_hold", 32'(sram_act_addr), N - 1);
      chk("idle_wdata", sram_act_wdata, 0);
      @(posedge clk); #1;
      chk("start_one_cycle", 32'(compute_start), 0);
      chk("wait_sel", 32'(sram_sel), 0);
   endtask

   // Core model: produce results, raise finish d cycles after the start
   // cycle; a level still high from the last run is dropped first.
   task automatic core_run(input int d, input bit ramp);
      for (int k = 0; k < N; k++)
         res[k] = ramp ? (32'(k) ^ 32'hA5A5A5A5) : $urandom;
      see_start();
      if (compute_finish) begin
         repeat (19) @(posedge clk);
         #1;
         chk("held_level_ignored", 32'(sram_sel), 0);
         compute_finish = 1'b0;
         repeat (d - 20) @(posedge clk);
      end else begin
         repeat (d - 1) @(posedge clk);
      end
      #1;
      compute_finish = 1'b1;
      chk("wait_no_valid", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("cycle_count", cycle_count, 32'(d));
      chk("rdreq_sel", 32'(sram_sel), 1);
      chk("rdreq_addr", 32'(sram_act_addr), OUT_BASE);
      chk("rdreq_wea", 32'(sram_act_wea), 0);
   endtask

   task automatic readback(input int stall_pct, input bit spacing,
                           input int abort_k, output bit aborted);
      int k = 0;
      int cyc = 0;
      int last_c = 0;
      bit prev_stall = 0;
      logic [31:0] prev_d = '0;
      aborted = 0;
      while (k < N && cyc < 5000) begin
         out_ready = ($urandom_range(0, 99) >= stall_pct);
         @(negedge clk);
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", out_data, prev_d);
         end
         if (out_valid && k == abort_k) begin
            aborted = 1;
            break;
         end
         if (out_valid) begin
            chk("out_last", 32'(out_last), 32'(k == N - 1));
            if (out_ready) begin
               chk("out_data", out_data, res[k]);
               if (spacing)
                  chk("word_gap", 32'(cyc - last_c), (k == 0) ? 2 : 3);
               last_c = cyc;
               k++;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      if (!aborted) begin
         chk("rd_words", 32'(k), N);
         chk("done_pulse", 32'(done), 1);
         chk("back_to_load", 32'(in_ready), 1);
         @(posedge clk); #1;
         chk("done_single", 32'(done), 0);
      end
   endtask

   initial begin
      bit ab;
      int ov0;
      rst_n          = 1'b0;
      in_valid       = 1'b0;
      in_data        = '0;
      out_ready      = 1'b0;
      compute_finish = 1'b0;
      #1;
      chk_idle_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < N; i++) img[i] = 32'(i);
      load_image(0);
      core_run(1000, 1);
      readback(0, 1, -1, ab);

      for (int i = 0; i < N; i++) img[i] = $urandom;
      load_image(0);
      core_run(50, 0);
      readback(30, 0, -1, ab);

      for (int i = 0; i < N; i++) img[i] = $urandom;
      load_image(0);
      see_start();
      compute_finish = 1'b0;
      ov0 = n_ov;
      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("tmo_err_early", 32'(err), 0);
      chk("tmo_still_wait", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("tmo_err", 32'(err), 1);
      chk("tmo_load", 32'(in_ready), 1);
      chk("tmo_sel", 32'(sram_sel), 1);
      chk("tmo_cycle_count", cycle_count, TMO);
      chk("tmo_no_readback", 32'(n_ov - ov0), 0);

      for (int i = 0; i < N; i++) img[i] = $urandom;
      load_image(1);
      core_run(300, 0);
      readback(20, 0, 10, ab);
      chk("abort_reached", 32'(ab), 1);
      rst_n = 1'b0;
      #1;
      chk_idle_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < N; i++) img[i] = $urandom;
      load_image(0);
      core_run(200, 0);
      readback(0, 1, -1, ab);

      chk("start_pulses", 32'(n_start), 5);
      chk("done_pulses", 32'(n_done), 3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
